// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Owns the PC, runs the multi-cycle
// imem request/done handshake, loads the fetch->decode (FD) register, keeps
// one returned instruction while decode stalls, and discards in-flight data
// after a redirect.
module fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_done,
    output logic [15:0] instr,
    output logic [15:0] pc_plus2,
    output logic        valid,
    output logic        align_err_o,
    output logic        fetch_busy
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        DROP   = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] pc;
    logic [15:0] pc_next;
    logic [15:0] pc_inc;
    logic [15:0] hold_instr;
    logic [15:0] hold_instr_next;
    logic [15:0] hold_pc2;
    logic [15:0] hold_pc2_next;
    logic        rdata_halt;
    logic        hold_halt;

    logic        fd_load;
    logic [15:0] fd_instr_next;
    logic [15:0] fd_pc2_next;
    logic        fd_valid_next;
    logic        fd_align_next;

    assign pc_inc     = pc + 16'd2;
    assign imem_addr  = pc;
    assign rdata_halt = (imem_rdata[15:11] == 5'b00000);
    assign hold_halt  = (hold_instr[15:11] == 5'b00000);

    // Next-state, PC, hold buffer, FD load values and handshake outputs.
    always_comb begin
        state_next      = state;
        pc_next         = pc;
        hold_instr_next = hold_instr;
        hold_pc2_next   = hold_pc2;
        fd_load         = 1'b0;
        fd_instr_next   = NOP_INSTR;
        fd_pc2_next     = 16'h0000;
        fd_valid_next   = 1'b0;
        fd_align_next   = 1'b0;
        imem_req        = 1'b0;
        fetch_busy      = 1'b0;

        case (state)
            FETCH: begin
                if (pc[0]) begin
                    // Misaligned PC: never issue the request, hand decode an
                    // error marker and stop.
                    if (!stall) begin
                        fd_load       = 1'b1;
                        fd_pc2_next   = pc_inc;
                        fd_valid_next = 1'b1;
                        fd_align_next = 1'b1;
                        state_next    = HALTED;
                    end
                end else begin
                    imem_req   = 1'b1;
                    fetch_busy = ~imem_done;
                    if (imem_done) begin
                        if (!rdata_halt) begin
                            pc_next = pc_inc;
                        end
                        if (!stall) begin
                            fd_load       = 1'b1;
                            fd_instr_next = imem_rdata;
                            fd_pc2_next   = pc_inc;
                            fd_valid_next = 1'b1;
                            if (rdata_halt) begin
                                state_next = HALTED;
                            end
                        end else begin
                            hold_instr_next = imem_rdata;
                            hold_pc2_next   = pc_inc;
                            state_next      = HOLD;
                        end
                    end else if (!stall) begin
                        fd_load = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (!stall) begin
                    fd_load         = 1'b1;
                    fd_instr_next   = hold_instr;
                    fd_pc2_next     = hold_pc2;
                    fd_valid_next   = 1'b1;
                    hold_instr_next = NOP_INSTR;
                    hold_pc2_next   = 16'h0000;
                    state_next      = hold_halt ? HALTED : FETCH;
                end
            end
            DROP: begin
                fetch_busy = ~imem_done;
                if (imem_done) begin
                    state_next = FETCH;
                end
                if (!stall) begin
                    fd_load = 1'b1;
                end
            end
            HALTED: begin
                if (!stall) begin
                    fd_load = 1'b1;
                end
            end
            default: begin
                state_next = FETCH;
            end
        endcase

        // A redirect beats stall and everything decided above; an unfinished
        // request must still be drained, so that case parks in DROP.
        if (redirect) begin
            pc_next         = redirect_pc;
            hold_instr_next = NOP_INSTR;
            hold_pc2_next   = 16'h0000;
            fd_load         = 1'b1;
            fd_instr_next   = NOP_INSTR;
            fd_pc2_next     = 16'h0000;
            fd_valid_next   = 1'b0;
            fd_align_next   = 1'b0;
            if ((imem_req || (state == DROP)) && !imem_done) begin
                state_next = DROP;
            end else begin
                state_next = FETCH;
            end
        end

        if (!rst) begin
            imem_req   = 1'b0;
            fetch_busy = 1'b0;
        end
    end

    // State, PC, hold buffer and FD pipeline register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            hold_instr  <= NOP_INSTR;
            hold_pc2    <= 16'h0000;
            instr       <= NOP_INSTR;
            pc_plus2    <= 16'h0000;
            valid       <= 1'b0;
            align_err_o <= 1'b0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            hold_instr <= hold_instr_next;
            hold_pc2   <= hold_pc2_next;
            if (fd_load) begin
                instr       <= fd_instr_next;
                pc_plus2    <= fd_pc2_next;
                valid       <= fd_valid_next;
                align_err_o <= fd_align_next;
            end
        end
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage: the producer end of the fetch→decode interface. It owns the PC and drives a multi-cycle instruction-memory request/done handshake. It delivers the 16-bit instr, pc_plus2 and valid into the FD pipeline register, and applies redirects from branch/jump resolution. It holds one returned instruction while decode stalls, and discards in-flight data after a redirect.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
NOP_INSTR, 16'h0800, bubble encoding driven on instr when no valid instruction

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low (asserted when 0, sampled at posedge clk)
stall  in  1  hazard unit: FD register must hold
redirect  in  1  branch/jump resolved taken or mispredicted; flush fetch
redirect_pc  in  16  new PC when redirect=1
imem_req  out  1  request valid to instruction memory
imem_addr  out  16  fetch address (= pc)
imem_rdata  in  16  returned instruction, valid when imem_done=1
imem_done  in  1  memory completes current request (1..N cycles after imem_req)
instr  out  16  FD register: instruction to decode
pc_plus2  out  16  FD register: fetched PC + 2
valid  out  1  FD register: instr is a real instruction
align_err_o  out  1  FD register: PC was odd; decode treats as halt
fetch_busy  out  1  1 while a request is outstanding and not yet done

Behaviour:
- Reset (rst=0 at posedge): pc=RESET_PC, state=FETCH, buffer empty, instr=NOP_INSTR, pc_plus2=0, valid=0, align_err_o=0. imem_req=0 in any cycle where rst=0.
- States: FETCH (request outstanding), HOLD (buffer full, decode stalled), DROP (discard in-flight response), HALTED.
- FETCH: imem_req=1, imem_addr=pc, fetch_busy=~imem_done. The address stays stable until imem_done.
  - If imem_done=0 and stall=0: FD loads instr=NOP_INSTR, valid=0 (bubble). If stall=1: FD holds.
  - If imem_done=1:
    - Compute next PC: pc<=pc+2 (mod 2^16; 16'hFFFE wraps to 16'h0000), except pc is unchanged when imem_rdata[15:11]==5'b00000 (halt).
    - If stall=0: FD<={imem_rdata, pc+2, valid=1}. Then go to HALTED if halt, else stay in FETCH.
    - If stall=1: capture into the buffer and go to HOLD.
- HOLD: imem_req=0. When stall drops, FD loads from the buffer (valid=1). Next state is HALTED if the buffered instr is halt, else FETCH. Buffer read and FD load take exactly one cycle.
- HALTED: imem_req=0. FD loads NOP/valid=0 when stall=0. PC frozen.
- Alignment: in FETCH with pc[0]=1, no request is issued (imem_req=0). When stall=0, FD<={NOP_INSTR, pc+2, valid=1, align_err_o=1}, then go to HALTED. align_err_o is 0 for every other FD load.
- Redirect (priority over all except reset, and over stall):
  - pc<=redirect_pc, buffer cleared, FD<={NOP_INSTR, 0, valid=0, align_err_o=0}.
  - If a request is outstanding and imem_done=0 that cycle, go to DROP.
  - Otherwise (including imem_done=1 in the same cycle, whose data is discarded), go to FETCH.
  - Redirect from HALTED or HOLD also goes to FETCH. A speculative halt is cancelled.
- DROP: imem_req=0 and fetch_busy=1 until imem_done. The response is discarded, then go to FETCH. A further redirect in DROP updates pc and stays in DROP.
- Latency: minimum one instruction per cycle when imem_done is same-cycle. Redirect-to-first-valid is 2 cycles with a single-cycle memory.

Test Plan:
- Reset then single-cycle memory returning 16'h4001 at 0x0000, 16'h4002 at 0x0002 → valid=1 in consecutive cycles, pc_plus2=0x0002 then 0x0004, imem_addr increments by 2.
- 3-cycle memory latency → imem_addr held for 3 cycles, two NOP bubbles (valid=0), then instr=returned word, fetch_busy high for 2 cycles.
- stall=1 for 4 cycles coinciding with imem_done → FD unchanged, state HOLD, no new imem_req. On stall release, instr=buffered word, then fetch resumes at pc+2.
- redirect=1, redirect_pc=0x0100 while a 3-cycle request is in flight → FD=NOP/valid=0, stale response discarded, next imem_addr=0x0100, first valid has pc_plus2=0x0102.
- Fetch 16'h0000 (halt) at 0x0010 → delivered with valid=1, then imem_req stays 0 and pc stays 0x0010. redirect to 0x0020 → fetch resumes at 0x0020.
- redirect_pc=0x0003 → no request issued, FD shows align_err_o=1, valid=1, instr=0x0800, then HALTED. Also check PC at 0xFFFE → pc_plus2=0x0000.
